// File: rtl/fifo.sv
// Width-converting FIFO: bytes in, nibbles out (low nibble first), 2*DEPTH nibble slots.
// Registered read data; empty/full decoded from the registered nibble count.
module fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] w_data,
    input  logic       rd,
    output logic [3:0] r_data,
    output logic       empty,
    output logic       full
);

    localparam int unsigned Slots = 2 * DEPTH;
    localparam int unsigned PtrW  = $clog2(Slots);
    localparam int unsigned CntW  = PtrW + 1;

    logic [3:0]      mem_q [Slots];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [3:0]      r_data_q, r_data_d;
    logic            wr_ok, rd_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q > CntW'(Slots - 2));
    assign r_data = r_data_q;

    // Both requests are qualified against the flags as they stood before the edge.
    assign wr_ok = wr & ~full;
    assign rd_ok = rd & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        r_data_d = r_data_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(2);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            r_data_d = mem_q[rd_ptr_q];
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CntW'(2);
            2'b01:   count_d = count_q - CntW'(1);
            2'b11:   count_d = count_q + CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            r_data_q <= 4'h0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            r_data_q <= r_data_d;
        end
    end

    // Storage is not reset; contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wr_ptr_q]              <= w_data[3:0];
            mem_q[wr_ptr_q + PtrW'(1)]   <= w_data[7:4];
        end
    end

endmodule

// File: tb/tb_fifo.sv
// Scoreboard bench for the byte-in/nibble-out FIFO: a nibble queue models contents,
// flags and registered read data, and every DUT output is compared after each edge.
module tb_fifo;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned SLOTS = 2 * DEPTH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] w_data = 8'h00;
    logic       rd = 1'b0;
    logic [3:0] r_data;
    logic       empty;
    logic       full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sb_q[$];
    logic [3:0] exp_r = 4'h0;

    fifo #(.DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .empty  (empty),
        .full   (full)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, update the model from pre-edge state, compare after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic rst,
                        input string tag);
        logic pre_empty, pre_full;
        @(negedge clk);
        wr = w; w_data = d; rd = r; reset = rst;
        pre_empty = (sb_q.size() == 0);
        pre_full  = (sb_q.size() > SLOTS - 2);
        if (rst) begin
            sb_q.delete();
            exp_r = 4'h0;
        end else begin
            if (r && !pre_empty) exp_r = sb_q.pop_front();
            if (w && !pre_full) begin
                sb_q.push_back(d[3:0]);
                sb_q.push_back(d[7:4]);
            end
        end
        @(posedge clk);
        #1;
        check_eq({tag, ".r_data"}, 32'(r_data), 32'(exp_r));
        check_eq({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
        check_eq({tag, ".full"}, 32'(full), 32'(sb_q.size() > SLOTS - 2));
    endtask

    task automatic idle(input string tag);
        step(1'b0, 8'h00, 1'b0, 1'b0, tag);
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0, 1'b1, "reset");
    endtask

    initial begin
        // Reset and fill/overflow
        do_reset(6);
        check_eq("rst_empty", 32'(empty), 32'd1);
        check_eq("rst_full", 32'(full), 32'd0);
        check_eq("rst_rdata", 32'(r_data), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
            if (i == 8) check_eq("full_after_8", 32'(full), 32'd1);
        end

        // Drain order: 1,0,2,0,3,0 with full dropping after the second read
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
            if (i == 0) check_eq("drain_full_1", 32'(full), 32'd1);
            if (i == 1) check_eq("drain_full_2", 32'(full), 32'd0);
        end
        check_eq("drain_last", 32'(r_data), 32'd0);

        // Underflow then 0xA5 round trip
        do_reset(1);
        step(1'b0, 8'h00, 1'b1, 1'b0, "underflow");
        check_eq("uf_rdata", 32'(r_data), 32'd0);
        check_eq("uf_empty", 32'(empty), 32'd1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, "wr_a5");
        step(1'b0, 8'h00, 1'b1, 1'b0, "rd_a5_lo");
        check_eq("a5_lo", 32'(r_data), 32'h5);
        step(1'b0, 8'h00, 1'b1, 1'b0, "rd_a5_hi");
        check_eq("a5_hi", 32'(r_data), 32'hA);
        check_eq("a5_empty", 32'(empty), 32'd1);

        // Simultaneous read/write at count 4
        step(1'b1, 8'h21, 1'b0, 1'b0, "sim_pre");
        step(1'b1, 8'h43, 1'b0, 1'b0, "sim_pre");
        step(1'b1, 8'h3C, 1'b1, 1'b0, "sim_rw");
        check_eq("sim_oldest", 32'(r_data), 32'h1);
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "sim_drain");
        check_eq("sim_tail", 32'(r_data), 32'h3);
        check_eq("sim_empty", 32'(empty), 32'd1);

        // Wrap-around: pointers start offset, three full rounds
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 8; i++)
                step(1'b1, 8'((round * 8 + i) * 7 + 8'h11), 1'b0, 1'b0, "wrap_fill");
            for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_drain");
        end

        // Reset mid-operation at count 7 with rd and wr asserted
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, "mid_fill");
        step(1'b0, 8'h00, 1'b1, 1'b0, "mid_rd");
        step(1'b1, 8'hEE, 1'b1, 1'b1, "mid_reset");
        check_eq("mid_empty", 32'(empty), 32'd1);
        check_eq("mid_full", 32'(full), 32'd0);
        check_eq("mid_rdata", 32'(r_data), 32'd0);
        step(1'b1, 8'h96, 1'b0, 1'b0, "post_wr");
        step(1'b1, 8'h7D, 1'b0, 1'b0, "post_wr");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, "post_rd");

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 63) == 0), "rand");
        idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
